// File: rtl/gpio_regs_param.sv
// gpio_regs_param: parametrised GPIO register bank with per-pin input synchronisation,
// debounce, edge interrupts (W1C status) and atomic set/clear/toggle of the output register.
// Optional: define GPIO_LEVEL_IRQ_EN to add the LVL register (0x34) for level interrupts.
module gpio_regs_param #(
    parameter int unsigned GPIO_W      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DBNC_W      = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              gpio_we,
    input  logic [31:0]       gpio_adr,
    input  logic [31:0]       gpio_dat_i,
    output logic [31:0]       gpio_dat_o,
    output logic              gpio_inta_o,
    input  logic [GPIO_W-1:0] aux_i,
    output logic [GPIO_W-1:0] out_pad_o,
    output logic [GPIO_W-1:0] oen_padoe_o,
    input  logic [GPIO_W-1:0] in_pad_i
);

    localparam logic [31:0] AdrIn     = 32'h00;
    localparam logic [31:0] AdrOut    = 32'h04;
    localparam logic [31:0] AdrOe     = 32'h08;
    localparam logic [31:0] AdrInte   = 32'h0C;
    localparam logic [31:0] AdrPtrig  = 32'h10;
    localparam logic [31:0] AdrAux    = 32'h14;
    localparam logic [31:0] AdrCtrl   = 32'h18;
    localparam logic [31:0] AdrInts   = 32'h1C;
    localparam logic [31:0] AdrBoth   = 32'h20;
    localparam logic [31:0] AdrOutSet = 32'h24;
    localparam logic [31:0] AdrOutClr = 32'h28;
    localparam logic [31:0] AdrOutTgl = 32'h2C;
    localparam logic [31:0] AdrDbnc   = 32'h30;
`ifdef GPIO_LEVEL_IRQ_EN
    localparam logic [31:0] AdrLvl    = 32'h34;
`endif

    // Register bank
    logic [GPIO_W-1:0] out_q, out_d, oe_q, oe_d, inte_q, inte_d, ptrig_q, ptrig_d;
    logic [GPIO_W-1:0] aux_q, aux_d, both_q, both_d, ints_q, ints_d;
    logic              ctrl_inte_q, ctrl_inte_d, ctrl_ints_q, ctrl_ints_d;
    logic [DBNC_W-1:0] dbnc_q, dbnc_d;
`ifdef GPIO_LEVEL_IRQ_EN
    logic [GPIO_W-1:0] lvl_q, lvl_d;
`endif

    // Input path
    logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_W-1:0] sync_d [SYNC_STAGES];
    logic [DBNC_W-1:0] cnt_q  [GPIO_W];
    logic [DBNC_W-1:0] cnt_d  [GPIO_W];
    logic [GPIO_W-1:0] stable_q, stable_d, stable_upd;

    // Interrupt and read path
    logic [GPIO_W-1:0] edge_evt, ints_set, ints_clr, wdat;
    logic              ctrl_clr, inta_q, inta_d;
    logic [31:0]       dat_q, dat_d;

    function automatic logic [31:0] zext(input logic [GPIO_W-1:0] v);
        return 32'(v);
    endfunction

    assign wdat        = gpio_dat_i[GPIO_W-1:0];
    assign gpio_dat_o  = dat_q;
    assign gpio_inta_o = inta_q;
    assign out_pad_o   = (out_q & ~aux_q) | (aux_q & aux_i);
    assign oen_padoe_o = oe_q;

    // Synchroniser chain: stage 0 samples the raw pads
    always_comb begin
        sync_d[0] = in_pad_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Debounce: a pin must hold a new value for DBNC+1 comparisons before stable follows
    always_comb begin
        stable_d   = stable_q;
        stable_upd = '0;
        for (int i = 0; i < GPIO_W; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_q[SYNC_STAGES-1][i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == dbnc_q) begin
                stable_d[i]   = sync_q[SYNC_STAGES-1][i];
                stable_upd[i] = 1'b1;
                cnt_d[i]      = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DBNC_W'(1);
            end
        end
    end

    // Interrupt sources: edge events, optionally replaced by level matches on LVL pins
    always_comb begin
        edge_evt = stable_upd & (both_q | ~(stable_d ^ ptrig_q));
`ifdef GPIO_LEVEL_IRQ_EN
        ints_set = ((edge_evt & ~lvl_q) | (lvl_q & ~(stable_q ^ ptrig_q)))
                   & inte_q & {GPIO_W{ctrl_inte_q}};
`else
        ints_set = edge_evt & inte_q & {GPIO_W{ctrl_inte_q}};
`endif
    end

    // Register writes; sets from events take priority over W1C clears
    always_comb begin
        out_d       = out_q;
        oe_d        = oe_q;
        inte_d      = inte_q;
        ptrig_d     = ptrig_q;
        aux_d       = aux_q;
        both_d      = both_q;
        ctrl_inte_d = ctrl_inte_q;
        dbnc_d      = dbnc_q;
`ifdef GPIO_LEVEL_IRQ_EN
        lvl_d       = lvl_q;
`endif
        ints_clr    = '0;
        ctrl_clr    = 1'b0;
        if (gpio_we) begin
            case (gpio_adr)
                AdrOut:    out_d   = wdat;
                AdrOe:     oe_d    = wdat;
                AdrInte:   inte_d  = wdat;
                AdrPtrig:  ptrig_d = wdat;
                AdrAux:    aux_d   = wdat;
                AdrCtrl: begin
                    ctrl_inte_d = gpio_dat_i[0];
                    ctrl_clr    = gpio_dat_i[1];
                end
                AdrInts:   ints_clr = wdat;
                AdrBoth:   both_d   = wdat;
                AdrOutSet: out_d    = out_q | wdat;
                AdrOutClr: out_d    = out_q & ~wdat;
                AdrOutTgl: out_d    = out_q ^ wdat;
                AdrDbnc:   dbnc_d   = gpio_dat_i[DBNC_W-1:0];
`ifdef GPIO_LEVEL_IRQ_EN
                AdrLvl:    lvl_d    = wdat;
`endif
                default: ;
            endcase
        end
        ints_d      = (ints_q & ~ints_clr) | ints_set;
        ctrl_ints_d = (ctrl_ints_q & ~ctrl_clr) | inta_q;
        inta_d      = ctrl_inte_q & (|ints_q);
    end

    // Read mux, registered into gpio_dat_o
    always_comb begin
        dat_d = '0;
        case (gpio_adr)
            AdrIn:    dat_d = zext(stable_q);
            AdrOut:   dat_d = zext(out_q);
            AdrOe:    dat_d = zext(oe_q);
            AdrInte:  dat_d = zext(inte_q);
            AdrPtrig: dat_d = zext(ptrig_q);
            AdrAux:   dat_d = zext(aux_q);
            AdrCtrl:  dat_d = {30'd0, ctrl_ints_q, ctrl_inte_q};
            AdrInts:  dat_d = zext(ints_q);
            AdrBoth:  dat_d = zext(both_q);
            AdrDbnc:  dat_d = 32'(dbnc_q);
`ifdef GPIO_LEVEL_IRQ_EN
            AdrLvl:   dat_d = zext(lvl_q);
`endif
            default:  dat_d = '0;
        endcase
    end

    // State registers, all cleared by asynchronous reset
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_q       <= '0;
            oe_q        <= '0;
            inte_q      <= '0;
            ptrig_q     <= '0;
            aux_q       <= '0;
            both_q      <= '0;
            ints_q      <= '0;
            ctrl_inte_q <= 1'b0;
            ctrl_ints_q <= 1'b0;
            dbnc_q      <= '0;
`ifdef GPIO_LEVEL_IRQ_EN
            lvl_q       <= '0;
`endif
            sync_q      <= '{default: '0};
            cnt_q       <= '{default: '0};
            stable_q    <= '0;
            inta_q      <= 1'b0;
            dat_q       <= '0;
        end else begin
            out_q       <= out_d;
            oe_q        <= oe_d;
            inte_q      <= inte_d;
            ptrig_q     <= ptrig_d;
            aux_q       <= aux_d;
            both_q      <= both_d;
            ints_q      <= ints_d;
            ctrl_inte_q <= ctrl_inte_d;
            ctrl_ints_q <= ctrl_ints_d;
            dbnc_q      <= dbnc_d;
`ifdef GPIO_LEVEL_IRQ_EN
            lvl_q       <= lvl_d;
`endif
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            inta_q      <= inta_d;
            dat_q       <= dat_d;
        end
    end

endmodule
